fetch_queue: RTL and testbench

Decoupling buffer between the IF stage and the ID stage. It holds up to DEPTH fetched packets, each made of PC, instruction word and the IF predictor's taken flag, so that an instruction-memory stall or a decode stall does not freeze the other side. Packets enter and leave under valid/ready handshakes. A flush from branch resolution empties the buffer.

---
 rtl/rv32i_types.sv | 13 +
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the fetched-packet record carried from IF to ID
// and the bubble encoding that IF also uses when it flushes.
package rv32i_types;

   localparam logic [31:0] FETCH_BUBBLE = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        pred;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: a small circular buffer between IF and ID so that an I-memory
// stall or a decode stall does not freeze the other side. Occupancy is kept in
// a separate count register so full and empty are simple compares.
module fetch_queue
   import rv32i_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     enq_valid,
   input  logic [31:0]              enq_pc,
   input  logic [31:0]              enq_ir,
   input  logic                     enq_pred,
   output logic                     enq_ready,
   output logic                     deq_valid,
   output logic [31:0]              deq_pc,
   output logic [31:0]              deq_ir,
   output logic                     deq_pred,
   input  logic                     deq_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_pkt_t    mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic empty;
   logic full;
   logic enqFire;
   logic deqFire;
   fetch_pkt_t headPkt;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign enq_ready = !full;
   assign deq_valid = !empty;
   assign enqFire   = enq_valid && !full;
   assign deqFire   = deq_ready && !empty;
   assign count     = count_q;

   // Head entry is presented directly; an empty queue shows a bubble instead of stale data.
   always_comb begin
      headPkt = mem_q[head_q];
      if (empty) begin
         deq_pc   = 32'h0;
         deq_ir   = FETCH_BUBBLE;
         deq_pred = 1'b0;
      end else begin
         deq_pc   = headPkt.pc;
         deq_ir   = headPkt.ir;
         deq_pred = headPkt.pred;
      end
   end

   // Next pointers and occupancy; a flush discards whatever handshakes happen in its cycle.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enqFire) begin
            tail_d = tail_q + PW'(1);
         end
         if (deqFire) begin
            head_d = head_q + PW'(1);
         end
         if (enqFire && !deqFire) begin
            count_d = count_q + CW'(1);
         end else if (deqFire && !enqFire) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Pointer/count state with async clear; storage is never cleared, only written on accepted enqueues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (enqFire && !flush) begin
            mem_q[tail_q] <= '{pc: enq_pc, ir: enq_ir, pred: enq_pred};
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (DEPTH=2): a directed vector table, a few hand-written
// corner sequences, and a randomized run checked against a queue-based model.
module tb_fetch_queue;
   import rv32i_types::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        enq_valid;
   logic [31:0] enq_pc;
   logic [31:0] enq_ir;
   logic        enq_pred;
   logic        enq_ready;
   logic        deq_valid;
   logic [31:0] deq_pc;
   logic [31:0] deq_ir;
   logic        deq_pred;
   logic        deq_ready;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   fetch_pkt_t    modelQ[$];
   logic [31:0]   dequeuedPcs[$];

   typedef struct {
      logic        fl;
      logic        ev;
      logic [31:0] pc;
      logic [31:0] ir;
      logic        pred;
      logic        dr;
      logic [1:0]  eCount;
      logic        eValid;
      logic [31:0] ePc;
      logic [31:0] eIr;
      logic        ePred;
      logic        eReady;
   } vec_t;

   vec_t vecs[14];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_pc    (enq_pc),
      .enq_ir    (enq_ir),
      .enq_pred  (enq_pred),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_pc    (deq_pc),
      .deq_ir    (deq_ir),
      .deq_pred  (deq_pred),
      .deq_ready (deq_ready),
      .count     (count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Compares every visible output against the model queue contents.
   task automatic compareModel(input string tag);
      checkOutput({tag, "_count"}, 32'(count), 32'(modelQ.size()));
      checkOutput({tag, "_deq_valid"}, 32'(deq_valid), 32'(modelQ.size() > 0));
      checkOutput({tag, "_enq_ready"}, 32'(enq_ready), 32'(modelQ.size() < DEPTH));
      if (modelQ.size() > 0) begin
         checkOutput({tag, "_deq_pc"}, deq_pc, modelQ[0].pc);
         checkOutput({tag, "_deq_ir"}, deq_ir, modelQ[0].ir);
         checkOutput({tag, "_deq_pred"}, 32'(deq_pred), 32'(modelQ[0].pred));
      end else begin
         checkOutput({tag, "_deq_pc"}, deq_pc, 32'h0);
         checkOutput({tag, "_deq_ir"}, deq_ir, 32'h0);
         checkOutput({tag, "_deq_pred"}, 32'(deq_pred), 32'h0);
      end
   endtask

   // One clock of stimulus, with the model advanced by the queue's rules.
   task automatic applyStimulus(input logic fl, input logic ev, input logic [31:0] pc,
                                input logic [31:0] ir, input logic pr, input logic dr);
      bit enqOk;
      bit deqOk;
      fetch_pkt_t pkt;
      flush     = fl;
      enq_valid = ev;
      enq_pc    = pc;
      enq_ir    = ir;
      enq_pred  = pr;
      deq_ready = dr;
      #1;
      compareModel("pre");
      enqOk = ev && (modelQ.size() < DEPTH);
      deqOk = dr && (modelQ.size() > 0);
      if (deqOk && !fl) begin
         dequeuedPcs.push_back(deq_pc);
      end
      @(posedge clk);
      #1;
      if (fl) begin
         modelQ.delete();
      end else begin
         if (deqOk) begin
            void'(modelQ.pop_front());
         end
         if (enqOk) begin
            pkt.pc   = pc;
            pkt.ir   = ir;
            pkt.pred = pr;
            modelQ.push_back(pkt);
         end
      end
      compareModel("post");
   endtask

   task automatic applyVector(input int idx);
      flush     = vecs[idx].fl;
      enq_valid = vecs[idx].ev;
      enq_pc    = vecs[idx].pc;
      enq_ir    = vecs[idx].ir;
      enq_pred  = vecs[idx].pred;
      deq_ready = vecs[idx].dr;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_count", idx), 32'(count), 32'(vecs[idx].eCount));
      checkOutput($sformatf("vec%0d_deq_valid", idx), 32'(deq_valid), 32'(vecs[idx].eValid));
      checkOutput($sformatf("vec%0d_deq_pc", idx), deq_pc, vecs[idx].ePc);
      checkOutput($sformatf("vec%0d_deq_ir", idx), deq_ir, vecs[idx].eIr);
      checkOutput($sformatf("vec%0d_deq_pred", idx), 32'(deq_pred), 32'(vecs[idx].ePred));
      checkOutput($sformatf("vec%0d_enq_ready", idx), 32'(enq_ready), 32'(vecs[idx].eReady));
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      modelQ.delete();
      @(posedge clk);
      #1;
   endtask

   // Main test sequence.
   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_pc    = '0;
      enq_ir    = '0;
      enq_pred  = 1'b0;
      deq_ready = 1'b0;

      //          fl  ev  pc        ir            pr  dr  cnt v   ePc       eIr           eP  eR
      vecs[0]  = '{0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 1};
      vecs[1]  = '{0, 1, 32'h60,  32'h00500093, 0, 0, 1, 1, 32'h60,  32'h00500093, 0, 1};
      vecs[2]  = '{0, 1, 32'h64,  32'h00100113, 1, 0, 2, 1, 32'h60,  32'h00500093, 0, 0};
      vecs[3]  = '{0, 1, 32'h68,  32'hdeadbeef, 0, 1, 1, 1, 32'h64,  32'h00100113, 1, 1};
      vecs[4]  = '{0, 1, 32'h68,  32'h00000213, 0, 0, 2, 1, 32'h64,  32'h00100113, 1, 0};
      vecs[5]  = '{0, 0, 32'h0,   32'h0,        0, 1, 1, 1, 32'h68,  32'h00000213, 0, 1};
      vecs[6]  = '{0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 32'h0,   32'h0,        0, 1};
      vecs[7]  = '{0, 1, 32'h80,  32'h00a00293, 1, 1, 1, 1, 32'h80,  32'h00a00293, 1, 1};
      vecs[8]  = '{0, 1, 32'h84,  32'h00000313, 0, 0, 2, 1, 32'h80,  32'h00a00293, 1, 0};
      vecs[9]  = '{1, 1, 32'h100, 32'h12345678, 1, 1, 0, 0, 32'h0,   32'h0,        0, 1};
      vecs[10] = '{0, 1, 32'h200, 32'h00000393, 0, 0, 1, 1, 32'h200, 32'h00000393, 0, 1};
      vecs[11] = '{0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 32'h0,   32'h0,        0, 1};
      vecs[12] = '{0, 1, 32'h80,  32'h00a00293, 1, 0, 1, 1, 32'h80,  32'h00a00293, 1, 1};
      vecs[13] = '{0, 1, 32'h84,  32'h00000313, 0, 1, 1, 1, 32'h84,  32'h00000313, 0, 1};

      doReset();
      checkOutput("reset_count", 32'(count), 32'h0);
      checkOutput("reset_deq_valid", 32'(deq_valid), 32'h0);
      checkOutput("reset_deq_ir", deq_ir, 32'h0);
      checkOutput("reset_enq_ready", 32'(enq_ready), 32'h1);

      for (int i = 0; i < 14; i++) begin
         applyVector(i);
      end

      // Fill to two entries, then assert reset mid-cycle and look before any edge.
      enq_valid = 1'b1;
      deq_ready = 1'b0;
      flush     = 1'b0;
      enq_pc    = 32'h300;
      @(posedge clk);
      #1;
      checkOutput("prereset_count", 32'(count), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_count", 32'(count), 32'h0);
      checkOutput("async_reset_deq_valid", 32'(deq_valid), 32'h0);
      checkOutput("async_reset_deq_ir", deq_ir, 32'h0);
      checkOutput("async_reset_enq_ready", 32'(enq_ready), 32'h1);
      enq_valid = 1'b0;
      doReset();

      // Flush while full: enq_ready keeps its pre-flush value during the flush cycle.
      applyStimulus(0, 1, 32'h400, 32'h11, 0, 0);
      applyStimulus(0, 1, 32'h404, 32'h22, 0, 0);
      applyStimulus(1, 1, 32'h100, 32'h33, 1, 1);
      applyStimulus(0, 1, 32'h200, 32'h44, 0, 0);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);

      // Streaming with deq_ready held high: order and count of delivered PCs.
      dequeuedPcs.delete();
      for (int i = 0; i <= 8; i++) begin
         applyStimulus(0, 1, 32'(i * 4), 32'(32'h1000 + i), i[0], 1);
      end
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
      checkOutput("stream_num_delivered", 32'(dequeuedPcs.size()), 32'd9);
      for (int i = 0; i < dequeuedPcs.size() && i < 9; i++) begin
         checkOutput($sformatf("stream_pc%0d", i), dequeuedPcs[i], 32'(i * 4));
      end

      // Randomized traffic against the model, including occasional flushes.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 16) == 0, ($urandom % 10) < 7,
                       $urandom & 32'hffff_fffc, $urandom, 1'($urandom),
                       ($urandom % 10) < 6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
